// File: rtl/dff_ram_arb_pkg.sv
// Shared definitions for the flop-RAM arbiter: default sizes, RAM command
// encodings and a small index helper used by the round-robin pointer.
package dff_ram_arb_pkg;

  localparam int DEFAULT_NUM_REQ = 2;
  localparam int DEFAULT_ADDR_W  = 2;
  localparam int DEFAULT_DATA_W  = 72;

  localparam logic RAM_CMD_WRITE = 1'b1;
  localparam logic RAM_CMD_READ  = 1'b0;
  localparam logic RAM_EN_ACTIVE = 1'b0;
  localparam logic RAM_EN_IDLE   = ~RAM_EN_ACTIVE;

  // Next requester index with wrap-around at n.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter. Default build is round-robin with a priority pointer.
// Defining DFF_RAM_ARB_FIXED_PRIO_EN turns it into a purely combinational
// fixed-priority arbiter (lowest index wins) with no pointer and no clock.
module rr_arbiter
  import dff_ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
`ifndef DFF_RAM_ARB_FIXED_PRIO_EN
  input  logic                       clk,
  input  logic                       rst_n,
`endif
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

`ifdef DFF_RAM_ARB_FIXED_PRIO_EN

  // Lowest asserted request index wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req[i]) begin
        grant_valid = 1'b1;
        grant[i]    = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end

`else

  logic [IDX_W-1:0] ptr;

  // Scan requesters starting at the pointer (wrapping); first asserted one wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_valid && req[i] &&
            (i == ((int'(ptr) + k >= NUM_REQ) ? int'(ptr) + k - NUM_REQ : int'(ptr) + k))) begin
          grant_valid = 1'b1;
          grant[i]    = 1'b1;
          grant_idx   = IDX_W'(i);
        end
      end
    end
  end

  // Pointer moves just past the granted requester; holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= IDX_W'(next_index(int'(grant_idx), NUM_REQ));
    end
  end

`endif

endmodule

// File: rtl/dff_ram_arbiter.sv
// Top level: shares one single-port flop RAM among NUM_REQ requesters.
// Arbitration lives in rr_arbiter; this file muxes the granted command onto
// the RAM port and steers the one-cycle-late read data back to its issuer.
// Optional macro DFF_RAM_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
module dff_ram_arbiter
  import dff_ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         ram_address,
  output logic                      ram_en_n,
  output logic                      ram_wr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               tag_pending;
  logic [IDX_W-1:0]   tag_id;

  // Nothing is granted while reset is held, so ready and the RAM port stay idle.
  assign req_masked = {NUM_REQ{rst_n}} & req_valid;
  assign req_ready  = grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
`ifndef DFF_RAM_ARB_FIXED_PRIO_EN
    .clk         (clk),
    .rst_n       (rst_n),
`endif
    .req         (req_masked),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Drive the RAM port from the granted requester's command; idle values otherwise.
  always_comb begin
    ram_en_n    = RAM_EN_IDLE;
    ram_wr      = RAM_CMD_READ;
    ram_address = '0;
    ram_wdata   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        ram_en_n    = RAM_EN_ACTIVE;
        ram_wr      = req_wr[i];
        ram_address = req_addr[i*ADDR_W +: ADDR_W];
        ram_wdata   = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Grant tag remembers which requester is owed read data next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pending <= 1'b0;
      tag_id      <= '0;
    end else begin
      tag_pending <= grant_valid && (ram_wr == RAM_CMD_READ);
      tag_id      <= grant_idx;
    end
  end

  // Present RAM read data to the tagged requester; bus is zero otherwise.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (tag_pending) begin
      rsp_rdata = ram_rdata;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (IDX_W'(i) == tag_id) begin
          rsp_valid[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dff_ram_arbiter.sv
// Self-checking bench for dff_ram_arbiter with a behavioural flop RAM.
// A reference arbiter model predicts grants; expected read responses are
// queued at grant time and compared one cycle later.
module tb_dff_ram_arbiter;

  localparam int N  = 2;
  localparam int AW = 2;
  localparam int DW = 72;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_wr;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     ram_address;
  logic              ram_en_n;
  logic              ram_wr;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] exp_mem [4];
  logic [DW-1:0] ram_mem [4];
  int            exp_ptr;
  int            dut_cnt [N];
  int            n_checks;
  int            n_fail;

  localparam logic [DW-1:0] D_SINGLE = 72'h12_3456_789A_BCDE_F012;
  localparam logic [DW-1:0] D_ONES   = {DW{1'b1}};

  dff_ram_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .ram_address (ram_address),
    .ram_en_n    (ram_en_n),
    .ram_wr      (ram_wr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port flop RAM with registered read data.
  always @(posedge clk) begin
    if (ram_en_n == 1'b0) begin
      if (ram_wr) ram_mem[ram_address] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_address];
    end
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req_valid[i]            = v;
    req_wr[i]               = wr;
    req_addr[i*AW +: AW]    = addr;
    req_wdata[i*DW +: DW]   = data;
  endtask

  // Reference arbiter: returns the expected granted index or -1.
  function automatic int exp_grant();
    if (!rst_n) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (exp_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: check response and grant, advance the model, step the clock.
  task automatic cycle();
    int            g;
    rsp_t          r;
    logic [N-1:0]  exp_rv;
    logic [DW-1:0] exp_rd;
    logic [AW-1:0] a;
    #1;
    exp_rv = '0;
    exp_rd = '0;
    if (exp_q.size() > 0) begin
      r      = exp_q.pop_front();
      exp_rv = N'(1) << r.id;
      exp_rd = r.data;
    end
    checkOutput("rsp_valid", DW'(rsp_valid), DW'(exp_rv));
    checkOutput("rsp_rdata", rsp_rdata, exp_rd);
    g = exp_grant();
    for (int i = 0; i < N; i++) dut_cnt[i] += int'(req_ready[i]);
    if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      checkOutput("req_ready", DW'(req_ready), DW'(N'(1) << g));
      checkOutput("ram_en_n", DW'(ram_en_n), DW'(1'b0));
      checkOutput("ram_wr", DW'(ram_wr), DW'(req_wr[g]));
      checkOutput("ram_address", DW'(ram_address), DW'(a));
      checkOutput("ram_wdata", ram_wdata, req_wdata[g*DW +: DW]);
      if (req_wr[g]) exp_mem[a] = req_wdata[g*DW +: DW];
      else           exp_q.push_back('{id: g, data: exp_mem[a]});
`ifndef DFF_RAM_ARB_FIXED_PRIO_EN
      exp_ptr = (g + 1) % N;
`endif
    end else begin
      checkOutput("req_ready_idle", DW'(req_ready), '0);
      checkOutput("ram_en_n_idle", DW'(ram_en_n), DW'(1'b1));
      checkOutput("ram_wr_idle", DW'(ram_wr), '0);
      checkOutput("ram_address_idle", DW'(ram_address), '0);
      checkOutput("ram_wdata_idle", ram_wdata, '0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    ram_rdata = '0;
    exp_ptr   = 0;
    n_checks  = 0;
    n_fail    = 0;
    for (int i = 0; i < 4; i++) begin
      exp_mem[i] = '0;
      ram_mem[i] = '0;
    end
    for (int i = 0; i < N; i++) dut_cnt[i] = 0;

    // Reset for two cycles, then idle.
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();

    // Single requester: write addr 2, then read it back.
    applyStimulus(0, 1'b1, 1'b1, 2'd2, D_SINGLE);
    cycle();
    applyStimulus(0, 1'b1, 1'b0, 2'd2, '0);
    cycle();
    applyStimulus(0, 1'b0, 1'b0, 2'd0, '0);
    cycle();

    // Preload addr 0 via req0 and addr 1 via req1.
    applyStimulus(0, 1'b1, 1'b1, 2'd0, 72'hA);
    cycle();
    applyStimulus(0, 1'b0, 1'b0, 2'd0, '0);
    applyStimulus(1, 1'b1, 1'b1, 2'd1, 72'hB);
    cycle();

    // Contention: both read; req0 first, req1 next.
    applyStimulus(0, 1'b1, 1'b0, 2'd0, '0);
    applyStimulus(1, 1'b1, 1'b0, 2'd1, '0);
    cycle();
    applyStimulus(0, 1'b0, 1'b0, 2'd0, '0);
    cycle();
    applyStimulus(1, 1'b0, 1'b0, 2'd0, '0);
    cycle();

    // Fairness: both constantly valid for 20 cycles.
    for (int i = 0; i < N; i++) dut_cnt[i] = 0;
    applyStimulus(0, 1'b1, 1'b0, 2'd0, '0);
    applyStimulus(1, 1'b1, 1'b0, 2'd1, '0);
    for (int c = 0; c < 20; c++) cycle();
`ifdef DFF_RAM_ARB_FIXED_PRIO_EN
    checkOutput("grants_req0", DW'(dut_cnt[0]), DW'(20));
    checkOutput("grants_req1", DW'(dut_cnt[1]), DW'(0));
`else
    checkOutput("grants_req0", DW'(dut_cnt[0]), DW'(10));
    checkOutput("grants_req1", DW'(dut_cnt[1]), DW'(10));
`endif
    applyStimulus(0, 1'b0, 1'b0, 2'd0, '0);
    applyStimulus(1, 1'b0, 1'b0, 2'd0, '0);
    cycle();

    // Write-then-read hazard on addr 3.
    applyStimulus(1, 1'b1, 1'b1, 2'd3, D_ONES);
    cycle();
    applyStimulus(1, 1'b0, 1'b0, 2'd0, '0);
    applyStimulus(0, 1'b1, 1'b0, 2'd3, '0);
    cycle();
    applyStimulus(0, 1'b0, 1'b0, 2'd0, '0);
    cycle();

    // Reset while a read response is pending.
    applyStimulus(0, 1'b1, 1'b0, 2'd2, '0);
    cycle();
    applyStimulus(0, 1'b0, 1'b0, 2'd0, '0);
    rst_n = 1'b0;
    #1;
    checkOutput("rsp_valid_async_drop", DW'(rsp_valid), '0);
    checkOutput("rsp_rdata_async_drop", rsp_rdata, '0);
    exp_q.delete();
    exp_ptr = 0;
    cycle();
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 2'd0, '0);
    applyStimulus(1, 1'b1, 1'b0, 2'd1, '0);
    cycle();
    applyStimulus(0, 1'b0, 1'b0, 2'd0, '0);
    cycle();
    applyStimulus(1, 1'b0, 1'b0, 2'd0, '0);
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_ram_arbiter.md
Name: dff_ram_arbiter

Overview:
- Shares one 4-entry x 72-bit flop RAM (single port: address, active-low enable, write strobe, write data, registered read data) between NUM_REQ requesters.
- Each requester issues read/write commands over a valid/ready handshake.
- The arbiter grants at most one command per cycle, round-robin, drives the RAM port, and routes the read response back to the issuing requester.
- Sits between client logic and the RAM macro; it is the only RAM driver.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 2, RAM address width.
- DATA_W, 72, RAM data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accepted this cycle.
- req_wr  in  NUM_REQ  per-requester command type: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, sliced the same way.
- rsp_valid  out  NUM_REQ  one-cycle pulse: read data for requester i is on rsp_rdata.
- rsp_rdata  out  DATA_W  shared read-data bus.
- ram_address  out  ADDR_W  to RAM address.
- ram_en_n  out  1  to RAM enable, active low.
- ram_wr  out  1  to RAM write strobe: 1 = write, 0 = read.
- ram_wdata  out  DATA_W  to RAM write data.
- ram_rdata  in  DATA_W  from RAM; valid the cycle after a read is enabled.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, ram_en_n=1, ram_wr=0, ram_address=0, ram_wdata=0, rsp_rdata=0. Priority pointer resets to requester 0.
- Grant logic is combinational each cycle. Among the asserted req_valid bits, the first one at or after the pointer (wrapping) is granted: req_ready[g]=1. All other ready bits stay 0.
- With a grant: ram_en_n=0, ram_wr=req_wr[g], ram_address=req_addr slice g, ram_wdata=req_wdata slice g. With no grant: ram_en_n=1 and the other RAM outputs hold 0.
- Pointer update: at each edge with a grant, the pointer becomes (g+1) mod NUM_REQ. With no grant, the pointer holds.
- Handshake:
  - A command transfers on a cycle with valid&&ready.
  - A requester keeps valid and its command fields stable until ready.
  - Valid may drop only after transfer; ready does not wait for valid.
- Write latency: 0 extra cycles. Data is in the RAM at the grant edge, with no response.
- Read latency: 1 cycle.
  - A registered grant-tag records {read_pending, requester id}.
  - On the next cycle rsp_valid[id]=1 and rsp_rdata=ram_rdata.
  - At all other times rsp_rdata=0.
- Back-to-back reads from any mix of requesters are fully pipelined: one response per cycle, no bubbles.
- Write to A, then read of A on the next cycle: the read returns the new data.
- Only one command per cycle, so read/write collisions cannot occur.
- Full throughput: with all requesters constantly valid, each is granted exactly once every NUM_REQ cycles. No starvation.
- Reset asserted mid-read: the pending response is dropped (rsp_valid=0 immediately, asynchronously) and the pointer returns to 0. RAM contents are not the arbiter's concern.

Optional Feature:
- Macro DFF_RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest requester index always wins and the pointer logic is removed. Starvation of higher indices is allowed.
- Undefined (default): round-robin as described above.

Decomposition:
- Package dff_ram_arb_pkg holds:
  - default NUM_REQ, ADDR_W, DATA_W;
  - RAM_CMD_WRITE=1'b1 and RAM_CMD_READ=1'b0;
  - RAM_EN_ACTIVE=1'b0.
- Sub-module rr_arbiter (request vector in; one-hot grant and grant index out; owns the pointer and the fixed-priority macro). The top level handles muxing and the response tag.

Test Plan:
- Reset, then idle: rst_n=0 for 2 cycles, then release with no valid -> all outputs at reset values, ram_en_n=1 throughout.
- Single-requester write/read: req0 writes addr 2 = 72'h12_3456_789A_BCDE_F012, then reads addr 2 -> ready=1 each cycle; rsp_valid[0] pulses 1 cycle after the read with the same data; rsp_valid[1] stays 0.
- Contention: req0 and req1 both valid with reads of addr 0 and addr 1 (preloaded 72'hA and 72'hB) -> req0 granted cycle 0, req1 cycle 1; rsp_valid[0] with 72'hA at cycle 1, rsp_valid[1] with 72'hB at cycle 2.
- Fairness: both constantly valid for 20 cycles -> grants alternate 0,1,0,1…, 10 each. With DFF_RAM_ARB_FIXED_PRIO_EN defined -> req0 gets all 20.
- Write-then-read hazard: req1 writes addr 3 = 72'hFF…FF, req0 reads addr 3 on the next cycle -> rsp_rdata=72'hFF…FF.
- Reset mid-read: a read is granted, then rst_n falls before the response edge -> rsp_valid stays 0; after release the next grant goes to req0.
